decode_stage: RTL and testbench

Instruction-decode stage of the five-stage RISC-V pipeline core. Consumes the IF/ID outputs (InstrD, PCD, PCPlus4D), decodes control, reads the register file, sign-extends the immediate and registers everything into the ID/EX pipeline register for the execute stage. Owns the architectural register file; the writeback stage writes it through the W-side ports.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/decode_stage_if.sv | 45 ++++
 rtl/reg_file.sv | 47 ++++
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline core: opcodes, control encodings
// and the ID/EX pipeline register payload.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immSrcT;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic              regWrite;
        logic              memWrite;
        logic              jump;
        logic              branch;
        logic              aluSrc;
        logic [1:0]        resultSrc;
        logic [2:0]        aluControl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   immExt;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcPlus4;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } idExT;

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard hooks and ID/EX outputs.
interface decode_stage_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]   InstrD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic              RegWriteW;
    logic [REG_AW-1:0] RdW;
    logic [XLEN-1:0]   ResultW;
    logic              FlushE;

    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic              ALUSrcE;
    logic [1:0]        ResultSrcE;
    logic [2:0]        ALUControlE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   ImmExtE;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RdE, Rs1E, Rs2E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RdE, Rs1E, Rs2E
    );

endinterface

// File: rtl/reg_file.sv
// Architectural 32x32 register file, x0 hardwired to zero.
// DECODE_WB_BYPASS_EN: forward the same-cycle writeback value to the read ports.
module reg_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEn,
    input  logic [REG_AW-1:0] writeAddr,
    input  logic [XLEN-1:0]   writeData,
    input  logic [REG_AW-1:0] readAddr1,
    input  logic [REG_AW-1:0] readAddr2,
    output logic [XLEN-1:0]   readData1,
    output logic [XLEN-1:0]   readData2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn && (writeAddr != '0)) begin
            regs[writeAddr] <= writeData;
        end
    end

    function automatic logic [XLEN-1:0] readPort(input logic [REG_AW-1:0] addr,
                                                 input logic [XLEN-1:0]   stored);
        logic [XLEN-1:0] val;
        val = stored;
`ifdef DECODE_WB_BYPASS_EN
        if (writeEn && (writeAddr != '0) && (writeAddr == addr)) begin
            val = writeData;
        end
`endif
        if (addr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    assign readData1 = readPort(readAddr1, regs[readAddr1]);
    assign readData2 = readPort(readAddr2, regs[readAddr2]);

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: control decode, register read, immediate
// extension and the ID/EX pipeline register. Optional macro: DECODE_WB_BYPASS_EN.
module decode_stage
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;

    assign op       = bus.InstrD[6:0];
    assign rd       = bus.InstrD[11:7];
    assign funct3   = bus.InstrD[14:12];
    assign rs1      = bus.InstrD[19:15];
    assign rs2      = bus.InstrD[24:20];
    assign funct7b5 = bus.InstrD[30];

    assign bus.Rs1D = rs1;
    assign bus.Rs2D = rs2;

    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrc;
    logic [1:0]  resultSrc;
    logic [1:0]  aluOp;
    immSrcT      immSrc;
    logic [2:0]  aluControl;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    // Main decoder; unknown opcodes decode to an all-zero NOP
    always_comb begin
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        aluSrc    = 1'b0;
        resultSrc = RES_ALU;
        aluOp     = 2'b00;
        immSrc    = IMM_I;
        case (op)
            OP_LOAD:   begin regWrite = 1'b1; aluSrc = 1'b1; resultSrc = RES_MEM; end
            OP_STORE:  begin immSrc = IMM_S; aluSrc = 1'b1; memWrite = 1'b1; end
            OP_R:      begin regWrite = 1'b1; aluOp = 2'b10; end
            OP_BRANCH: begin immSrc = IMM_B; branch = 1'b1; aluOp = 2'b01; end
            OP_IMM:    begin regWrite = 1'b1; aluSrc = 1'b1; aluOp = 2'b10; end
            OP_JAL:    begin regWrite = 1'b1; immSrc = IMM_J; resultSrc = RES_PC4; jump = 1'b1; end
            default:   ;
        endcase
    end

    // ALU decoder; only R-type honours funct7[5] as subtract
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            2'b01: aluControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  aluControl = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

    always_comb begin
        immExt = '0;
        case (immSrc)
            IMM_I: immExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
            IMM_S: immExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            IMM_B: immExt = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                             bus.InstrD[11:8], 1'b0};
            IMM_J: immExt = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                             bus.InstrD[30:21], 1'b0};
            default: immExt = '0;
        endcase
    end

    reg_file u_regFile (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (bus.RegWriteW),
        .writeAddr (bus.RdW),
        .writeData (bus.ResultW),
        .readAddr1 (rs1),
        .readAddr2 (rs2),
        .readData1 (rd1),
        .readData2 (rd2)
    );

    idExT idExNext;
    idExT idEx;

    always_comb begin
        idExNext            = '0;
        idExNext.regWrite   = regWrite;
        idExNext.memWrite   = memWrite;
        idExNext.jump       = jump;
        idExNext.branch     = branch;
        idExNext.aluSrc     = aluSrc;
        idExNext.resultSrc  = resultSrc;
        idExNext.aluControl = aluControl;
        idExNext.rd1        = rd1;
        idExNext.rd2        = rd2;
        idExNext.immExt     = immExt;
        idExNext.pc         = bus.PCD;
        idExNext.pcPlus4    = bus.PCPlus4D;
        idExNext.rd         = rd;
        idExNext.rs1        = rs1;
        idExNext.rs2        = rs2;
    end

    // ID/EX register; flush loads an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idEx <= '0;
        end else if (bus.FlushE) begin
            idEx <= '0;
        end else begin
            idEx <= idExNext;
        end
    end

    assign bus.RegWriteE   = idEx.regWrite;
    assign bus.MemWriteE   = idEx.memWrite;
    assign bus.JumpE       = idEx.jump;
    assign bus.BranchE     = idEx.branch;
    assign bus.ALUSrcE     = idEx.aluSrc;
    assign bus.ResultSrcE  = idEx.resultSrc;
    assign bus.ALUControlE = idEx.aluControl;
    assign bus.RD1E        = idEx.rd1;
    assign bus.RD2E        = idEx.rd2;
    assign bus.ImmExtE     = idEx.immExt;
    assign bus.PCE         = idEx.pc;
    assign bus.PCPlus4E    = idEx.pcPlus4;
    assign bus.RdE         = idEx.rd;
    assign bus.Rs1E        = idEx.rs1;
    assign bus.Rs2E        = idEx.rs2;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    logic clk;
    logic rst;
    int   checkCnt;
    int   errCnt;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one decode cycle on the falling edge, sample just after the rising edge
    task automatic cycle(input logic [31:0] instr, input logic [31:0] pc,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic flush);
        @(negedge clk);
        bus.InstrD    = instr;
        bus.PCD       = pc;
        bus.PCPlus4D  = pc + 32'd4;
        bus.RegWriteW = we;
        bus.RdW       = wa;
        bus.ResultW   = wd;
        bus.FlushE    = flush;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sameCycleExp;

    initial begin
        checkCnt      = 0;
        errCnt        = 0;
        rst           = 1'b1;
        bus.InstrD    = '0;
        bus.PCD       = '0;
        bus.PCPlus4D  = '0;
        bus.RegWriteW = 1'b0;
        bus.RdW       = '0;
        bus.ResultW   = '0;
        bus.FlushE    = 1'b0;

        #12;
        checkEq("reset_regwrite", 32'(bus.RegWriteE), 32'd0);
        checkEq("reset_pce", bus.PCE, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // write x5 = 0xAA
        cycle(32'h0000_0000, 32'h100, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
        checkEq("nop_regwrite", 32'(bus.RegWriteE), 32'd0);

        // add x6,x5,x5
        cycle(32'h0052_8333, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("add_rs1d", 32'(bus.Rs1D), 32'd5);
        checkEq("add_rd1", bus.RD1E, 32'h0000_00AA);
        checkEq("add_rd2", bus.RD2E, 32'h0000_00AA);
        checkEq("add_regwrite", 32'(bus.RegWriteE), 32'd1);
        checkEq("add_aluctl", 32'(bus.ALUControlE), 32'd0);
        checkEq("add_rde", 32'(bus.RdE), 32'd6);
        checkEq("add_pce", bus.PCE, 32'h104);
        checkEq("add_pcplus4e", bus.PCPlus4E, 32'h108);

        // sub x6,x5,x5
        cycle(32'h4052_8333, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("sub_aluctl", 32'(bus.ALUControlE), 32'd1);

        // lw x6,-4(x8)
        cycle(32'hFFC4_2303, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("lw_imm", bus.ImmExtE, 32'hFFFF_FFFC);
        checkEq("lw_ressrc", 32'(bus.ResultSrcE), 32'd1);
        checkEq("lw_alusrc", 32'(bus.ALUSrcE), 32'd1);
        checkEq("lw_rs1e", 32'(bus.Rs1E), 32'd8);

        // beq x4,x4,-12
        cycle(32'hFE42_0AE3, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("beq_branch", 32'(bus.BranchE), 32'd1);
        checkEq("beq_aluctl", 32'(bus.ALUControlE), 32'd1);
        checkEq("beq_imm", bus.ImmExtE, 32'hFFFF_FFF4);
        checkEq("beq_regwrite", 32'(bus.RegWriteE), 32'd0);
        checkEq("beq_rs2e", 32'(bus.Rs2E), 32'd4);

        // ori x3,x5,-1
        cycle(32'hFFF2_E193, 32'h114, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("ori_aluctl", 32'(bus.ALUControlE), 32'd3);
        checkEq("ori_imm", bus.ImmExtE, 32'hFFFF_FFFF);
        checkEq("ori_rd1", bus.RD1E, 32'h0000_00AA);

        // jal x1,16
        cycle(32'h0100_00EF, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("jal_jump", 32'(bus.JumpE), 32'd1);
        checkEq("jal_ressrc", 32'(bus.ResultSrcE), 32'd2);
        checkEq("jal_imm", bus.ImmExtE, 32'h0000_0010);
        checkEq("jal_aluctl", 32'(bus.ALUControlE), 32'd0);

        // sw x5,8(x2)
        cycle(32'h0051_2423, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("sw_memwrite", 32'(bus.MemWriteE), 32'd1);
        checkEq("sw_imm", bus.ImmExtE, 32'h0000_0008);
        checkEq("sw_rd2", bus.RD2E, 32'h0000_00AA);
        checkEq("sw_regwrite", 32'(bus.RegWriteE), 32'd0);

        // attempt to write x0, then read it
        cycle(32'h0000_0000, 32'h120, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0);
        cycle(32'h0000_0333, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("x0_rd1", bus.RD1E, 32'd0);
        checkEq("x0_rd2", bus.RD2E, 32'd0);

        // flushed sw becomes a bubble
        cycle(32'h0051_2423, 32'h128, 1'b0, 5'd0, 32'h0, 1'b1);
        checkEq("flush_memwrite", 32'(bus.MemWriteE), 32'd0);
        checkEq("flush_imm", bus.ImmExtE, 32'd0);
        checkEq("flush_rd2", bus.RD2E, 32'd0);
        checkEq("flush_pce", bus.PCE, 32'd0);

        // same-cycle writeback vs read of x7
        cycle(32'h0000_0000, 32'h12C, 1'b1, 5'd7, 32'h0000_0055, 1'b0);
`ifdef DECODE_WB_BYPASS_EN
        sameCycleExp = 32'h0000_1234;
`else
        sameCycleExp = 32'h0000_0055;
`endif
        cycle(32'h0003_80B3, 32'h130, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
        checkEq("samecyc_rd1", bus.RD1E, sameCycleExp);
        cycle(32'h0003_80B3, 32'h134, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("nextcyc_rd1", bus.RD1E, 32'h0000_1234);

        // asynchronous reset mid-run
        cycle(32'h0051_2423, 32'h138, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("pre_rst_memwrite", 32'(bus.MemWriteE), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkEq("rst_memwrite", 32'(bus.MemWriteE), 32'd0);
        checkEq("rst_imm", bus.ImmExtE, 32'd0);
        checkEq("rst_rd2", bus.RD2E, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(32'h0052_8333, 32'h13C, 1'b0, 5'd0, 32'h0, 1'b0);
        checkEq("post_rst_rd1", bus.RD1E, 32'd0);
        checkEq("post_rst_regwrite", 32'(bus.RegWriteE), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
